// File: rtl/byte_packer.sv
// Packs a W-bit beat stream into little-endian W*N-bit words with a per-lane valid mask.
// A level flush emits a partially filled word; the output port is a registered ready/valid slot.
module byte_packer #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [W-1:0]           io_in_bits,
  input  logic                   io_flush,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [W*N-1:0]         io_out_bits,
  output logic [N-1:0]           io_out_mask,
  output logic [$clog2(N):0]     io_count
);

  localparam int LW = $clog2(N);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0][W-1:0] lane_q;
  logic [N-1:0][W-1:0] word_d;
  logic [N-1:0]        mask_d;
  logic [CW-1:0]       count_q;
  logic                out_valid_q;
  logic [W*N-1:0]      out_bits_q;
  logic [N-1:0]        out_mask_q;

  logic slot_free;
  logic in_fire;
  logic out_fire;
  logic complete;
  logic flush_only;
  logic emit;

  assign slot_free   = !out_valid_q | io_out_ready;
  assign io_in_ready = ((count_q != LAST) & !io_flush) | slot_free;
  assign in_fire     = io_in_valid & io_in_ready;
  assign out_fire    = out_valid_q & io_out_ready;
  // Either completion condition clears the first ready term, so a completing beat implies slot_free.
  assign complete    = in_fire & ((count_q == LAST) | io_flush);
  assign flush_only  = io_flush & !in_fire & (count_q != '0) & slot_free;
  assign emit        = complete | flush_only;

  // Lanes at or above count are stale; only held lanes and the incoming beat reach the word.
  always_comb begin
    word_d = '0;
    mask_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (CW'(k) < count_q) begin
        word_d[k] = lane_q[k];
        mask_d[k] = 1'b1;
      end else if ((CW'(k) == count_q) && in_fire) begin
        word_d[k] = io_in_bits;
        mask_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_mask_q  <= '0;
    end else if (emit) begin
      out_bits_q  <= word_d;
      out_mask_q  <= mask_d;
      out_valid_q <= 1'b1;
      count_q     <= '0;
    end else begin
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      if (in_fire) begin
        lane_q[count_q[LW-1:0]] <= io_in_bits;
        count_q                 <= count_q + CW'(1);
      end
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out_bits  = out_bits_q;
  assign io_out_mask  = out_mask_q;
  assign io_count     = count_q;

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios plus random traffic,
// all compared against a queue-based word-assembly model.
module tb_byte_packer;

  localparam int W = 8;
  localparam int N = 4;

  logic          clk;
  logic          reset;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [W-1:0]  io_in_bits;
  logic          io_flush;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [W*N-1:0] io_out_bits;
  logic [N-1:0]  io_out_mask;
  logic [2:0]    io_count;

  int n_tests;
  int n_fail;

  logic [7:0]  m_q[$];
  logic        m_valid;
  logic [31:0] m_bits;
  logic [3:0]  m_mask;

  byte_packer #(.W(W), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_bits  (io_in_bits),
    .io_flush    (io_flush),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_bits (io_out_bits),
    .io_out_mask (io_out_mask),
    .io_count    (io_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_bits  = '0;
    m_mask  = '0;
  endtask

  task automatic model_emit();
    m_bits = '0;
    for (int i = 0; i < m_q.size(); i++) m_bits |= 32'(m_q[i]) << (8 * i);
    m_mask  = 4'((1 << m_q.size()) - 1);
    m_q.delete();
    m_valid = 1'b1;
  endtask

  // One clock: drive after the falling edge, compare mid-cycle, advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [7:0] b, input logic f, input logic r);
    logic slot_free, exp_ready, fire, done;
    @(negedge clk);
    io_in_valid  = v;
    io_in_bits   = b;
    io_flush     = f;
    io_out_ready = r;
    #1;
    slot_free = !m_valid || r;
    exp_ready = ((m_q.size() != N - 1) && !f) || slot_free;
    check("in_ready",  32'(io_in_ready),  32'(exp_ready));
    check("out_valid", 32'(io_out_valid), 32'(m_valid));
    check("out_bits",  io_out_bits,       m_bits);
    check("out_mask",  32'(io_out_mask),  32'(m_mask));
    check("count",     32'(io_count),     32'(m_q.size()));
    @(posedge clk);
    fire = v && exp_ready;
    done = 1'b0;
    if (fire) begin
      m_q.push_back(b);
      if (m_q.size() == N || f) begin
        model_emit();
        done = 1'b1;
      end
    end else if (f && m_q.size() > 0 && slot_free) begin
      model_emit();
      done = 1'b1;
    end
    if (!done && m_valid && r) m_valid = 1'b0;
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 8'h00, 1'b0, r);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_flush     = 1'b0;
    io_out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(io_in_ready), 32'd1);
    check("rst_valid", 32'(io_out_valid), 32'd0);
    reset = 1'b1;

    // Basic pack
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b1, 8'h22, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    cycle(1'b1, 8'h44, 1'b0, 1'b1);
    #1;
    check("basic_bits", io_out_bits, 32'h44332211);
    check("basic_mask", 32'(io_out_mask), 32'hF);
    idle(1'b1);
    idle(1'b1);

    // Streaming
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
    #1;
    check("stream_last", io_out_bits, 32'h0B0A0908);
    idle(1'b1);

    // Backpressure
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    #1;
    check("bp_held", io_out_bits, 32'hA3A2A1A0);
    check("bp_count", 32'(io_count), 32'd3);
    cycle(1'b1, 8'hA7, 1'b0, 1'b0);
    cycle(1'b1, 8'hA7, 1'b0, 1'b1);
    #1;
    check("bp_next", io_out_bits, 32'hA7A6A5A4);
    idle(1'b1);

    // Partial flush, then a flush with nothing buffered
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    cycle(1'b1, 8'hBB, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    check("pflush_bits", io_out_bits, 32'h0000BBAA);
    check("pflush_mask", 32'(io_out_mask), 32'h3);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);

    // Flush together with a byte, including the single-byte word at count 0
    cycle(1'b1, 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b1, 1'b1);
    #1;
    check("bflush_bits", io_out_bits, 32'h00000201);
    check("bflush_cnt", 32'(io_count), 32'd0);
    cycle(1'b1, 8'h5C, 1'b1, 1'b1);
    #1;
    check("one_mask", 32'(io_out_mask), 32'h1);
    idle(1'b1);

    // Async reset with a pending word and 3 buffered bytes
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(io_out_valid), 32'd0);
    check("arst_count", 32'(io_count), 32'd0);
    model_reset();
    io_in_valid = 1'b0;
    io_flush    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b1);
    #1;
    check("arst_word", io_out_bits, 32'hD3D2D1D0);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
    end
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
